// File: rtl/spi_master_engine_if.sv
`default_nettype none
//==============================================================================
// Module : spi_master_engine_if
// Desc   : Command/response handshake and SPI pins of spi_master_engine.
// Rev    : 1.0
//==============================================================================
interface spi_master_engine_if #(
    parameter int DATA_DLENGTH = 16
);
    logic                    tx_valid;
    logic                    tx_ready;
    logic [DATA_DLENGTH-1:0] tx_data;
    logic                    rx_valid;
    logic [DATA_DLENGTH-1:0] rx_data;
    logic                    busy;
    logic                    spi_sclk;
    logic                    spi_mosi;
    logic                    spi_miso;
    logic                    spi_cs;

    modport master (
        input  tx_valid, tx_data, spi_miso,
        output tx_ready, rx_valid, rx_data, busy, spi_sclk, spi_mosi, spi_cs
    );

    modport slave (
        output tx_valid, tx_data, spi_miso,
        input  tx_ready, rx_valid, rx_data, busy, spi_sclk, spi_mosi, spi_cs
    );
endinterface
`default_nettype wire

// File: rtl/spi_master_engine.sv
`default_nettype none
//==============================================================================
// Module : spi_master_engine
// Desc   : SPI initiator, one MSB-first word per accepted command.
// Rev    : 1.0
//==============================================================================
module spi_master_engine #(
    parameter int CPOL         = 0,
    parameter int CPHA         = 0,
    parameter int INV_CS       = 0,
    parameter int DATA_DLENGTH = 16,
    parameter int CLK_DIV      = 4,
    parameter int CS_TO_SCLK   = 2,
    parameter int CS_GAP       = 2
) (
    input  logic                clk,
    input  logic                resetn,
    spi_master_engine_if.master bus
);

    localparam int   N          = DATA_DLENGTH;
    localparam logic c_cpol     = (CPOL != 0);
    localparam logic c_cpha     = (CPHA != 0);
    localparam logic c_cs_on    = (INV_CS != 0);
    localparam logic c_cs_off   = ~c_cs_on;
    localparam int   c_cnt_max  = (CS_TO_SCLK > CLK_DIV) ?
                                  ((CS_TO_SCLK > CS_GAP) ? CS_TO_SCLK : CS_GAP) :
                                  ((CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP);
    localparam int   c_cnt_w    = $clog2(c_cnt_max + 1);
    localparam int   c_edge_w   = $clog2(2 * N);

    localparam logic [c_cnt_w-1:0]  c_s_last    = c_cnt_w'(CS_TO_SCLK - 1);
    localparam logic [c_cnt_w-1:0]  c_d_last    = c_cnt_w'(CLK_DIV - 1);
    localparam logic [c_cnt_w-1:0]  c_g_last    = c_cnt_w'(CS_GAP - 1);
    localparam logic [c_edge_w-1:0] c_last_edge = c_edge_w'(2 * N - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } state_t;

    state_t                r_state,    w_state;
    logic [c_cnt_w-1:0]    r_cnt,      w_cnt;
    logic [c_edge_w-1:0]   r_edge,     w_edge;
    logic                  r_sclk,     w_sclk;
    logic                  r_mosi,     w_mosi;
    logic                  r_cs,       w_cs;
    logic [N-1:0]          r_tx_sh,    w_tx_sh;
    logic [N-1:0]          r_rx_sh,    w_rx_sh;
    logic                  r_rx_valid, w_rx_valid;
    logic [N-1:0]          r_rx_data,  w_rx_data;
    logic                  r_tx_ready, w_tx_ready;
    logic                  r_busy,     w_busy;

    logic                  w_fire;
    logic [c_edge_w-1:0]   w_edge_idx;
    logic                  w_leading;
    logic                  w_sample;

    always_comb begin
        w_state    = r_state;
        w_cnt      = r_cnt + 1'b1;
        w_edge     = r_edge;
        w_sclk     = r_sclk;
        w_mosi     = r_mosi;
        w_cs       = r_cs;
        w_tx_sh    = r_tx_sh;
        w_rx_sh    = r_rx_sh;
        w_rx_valid = 1'b0;
        w_rx_data  = r_rx_data;
        w_fire     = 1'b0;
        w_edge_idx = r_edge;
        w_leading  = 1'b0;
        w_sample   = 1'b0;

        unique case (r_state)
            IDLE: begin
                w_cnt = '0;
                if (bus.tx_valid && r_tx_ready) begin
                    w_state = SETUP;
                    w_cs    = c_cs_on;
                    w_tx_sh = bus.tx_data;
                    w_rx_sh = '0;
                    w_edge  = '0;
                    w_mosi  = c_cpha ? 1'b0 : bus.tx_data[N-1];
                end
            end
            // Edge 0 is launched on the transition out of SETUP.
            SETUP: begin
                if (r_cnt == c_s_last) begin
                    w_state    = SHIFT;
                    w_cnt      = '0;
                    w_fire     = 1'b1;
                    w_edge_idx = '0;
                    w_edge     = c_edge_w'(1);
                end
            end
            SHIFT: begin
                if (r_cnt == c_d_last) begin
                    w_cnt  = '0;
                    w_fire = 1'b1;
                    if (r_edge == c_last_edge) begin
                        w_state = HOLD;
                    end else begin
                        w_edge = r_edge + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (r_cnt == c_d_last) begin
                    w_state    = GAP;
                    w_cnt      = '0;
                    w_cs       = c_cs_off;
                    w_mosi     = 1'b0;
                    w_rx_valid = 1'b1;
                    w_rx_data  = r_rx_sh;
                end
            end
            GAP: begin
                if (r_cnt == c_g_last) begin
                    w_state = IDLE;
                    w_cnt   = '0;
                end
            end
            default: w_state = IDLE;
        endcase

        // Even edges lead, odd edges trail; CPHA picks which one samples.
        if (w_fire) begin
            w_sclk    = ~r_sclk;
            w_leading = ~w_edge_idx[0];
            w_sample  = w_leading ^ c_cpha;
            if (w_sample) begin
                w_rx_sh = {r_rx_sh[N-2:0], bus.spi_miso};
            end
            if (c_cpha && w_leading) begin
                w_mosi  = r_tx_sh[N-1];
                w_tx_sh = {r_tx_sh[N-2:0], 1'b0};
            end else if (!c_cpha && !w_leading && (w_edge_idx != c_last_edge)) begin
                w_mosi  = r_tx_sh[N-2];
                w_tx_sh = {r_tx_sh[N-2:0], 1'b0};
            end
        end

        w_tx_ready = (w_state == IDLE);
        w_busy     = (w_state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_edge     <= '0;
            r_sclk     <= c_cpol;
            r_mosi     <= 1'b0;
            r_cs       <= c_cs_off;
            r_tx_sh    <= '0;
            r_rx_sh    <= '0;
            r_rx_valid <= 1'b0;
            r_rx_data  <= '0;
            r_tx_ready <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_cnt      <= w_cnt;
            r_edge     <= w_edge;
            r_sclk     <= w_sclk;
            r_mosi     <= w_mosi;
            r_cs       <= w_cs;
            r_tx_sh    <= w_tx_sh;
            r_rx_sh    <= w_rx_sh;
            r_rx_valid <= w_rx_valid;
            r_rx_data  <= w_rx_data;
            r_tx_ready <= w_tx_ready;
            r_busy     <= w_busy;
        end
    end

    assign bus.tx_ready = r_tx_ready;
    assign bus.busy     = r_busy;
    assign bus.rx_valid = r_rx_valid;
    assign bus.rx_data  = r_rx_data;
    assign bus.spi_sclk = r_sclk;
    assign bus.spi_mosi = r_mosi;
    assign bus.spi_cs   = r_cs;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_engine.sv
`default_nettype none
//==============================================================================
// Module : tb_spi_master_engine
// Desc   : Three engine configurations (mode 0, mode 3 + slave model, 8-bit).
// Rev    : 1.0
//==============================================================================
module tb_spi_master_engine;

    logic clk;
    logic rstn [3];
    logic tv   [3];
    logic [15:0] td [3];
    int n_tests = 0;
    int n_fail  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    spi_master_engine_if #(.DATA_DLENGTH(16)) if0 ();
    spi_master_engine_if #(.DATA_DLENGTH(16)) if1 ();
    spi_master_engine_if #(.DATA_DLENGTH(8))  if2 ();

    spi_master_engine #(.CPOL(0), .CPHA(0), .INV_CS(0), .DATA_DLENGTH(16),
                        .CLK_DIV(4), .CS_TO_SCLK(2), .CS_GAP(2))
        u_dut0 (.clk(clk), .resetn(rstn[0]), .bus(if0));
    spi_master_engine #(.CPOL(1), .CPHA(1), .INV_CS(0), .DATA_DLENGTH(16),
                        .CLK_DIV(4), .CS_TO_SCLK(2), .CS_GAP(2))
        u_dut1 (.clk(clk), .resetn(rstn[1]), .bus(if1));
    spi_master_engine #(.CPOL(0), .CPHA(0), .INV_CS(1), .DATA_DLENGTH(8),
                        .CLK_DIV(1), .CS_TO_SCLK(1), .CS_GAP(2))
        u_dut2 (.clk(clk), .resetn(rstn[2]), .bus(if2));

    assign if0.tx_valid = tv[0];
    assign if1.tx_valid = tv[1];
    assign if2.tx_valid = tv[2];
    assign if0.tx_data  = td[0];
    assign if1.tx_data  = td[1];
    assign if2.tx_data  = td[2][7:0];
    assign if0.spi_miso = if0.spi_mosi;
    assign if2.spi_miso = if2.spi_mosi;

    // Mode-3 peripheral: drives on falling SCLK, samples on rising SCLK.
    logic [15:0] s_word, s_tx, s_rx;
    logic        s_miso;
    assign if1.spi_miso = s_miso;
    initial s_miso = 1'b0;
    always @(negedge if1.spi_cs) begin
        s_tx <= s_word;
        s_rx <= '0;
    end
    always @(negedge if1.spi_sclk) begin
        if (if1.spi_cs == 1'b0) begin
            s_miso <= s_tx[15];
            s_tx   <= {s_tx[14:0], 1'b0};
        end
    end
    always @(posedge if1.spi_sclk) begin
        if (if1.spi_cs == 1'b0) s_rx <= {s_rx[14:0], if1.spi_mosi};
    end

    logic [2:0]  obs_cs, obs_sclk, obs_mosi, obs_rdy, obs_busy, obs_rxv;
    logic [15:0] obs_rxd [3];
    assign obs_cs   = {if2.spi_cs,   if1.spi_cs,   if0.spi_cs};
    assign obs_sclk = {if2.spi_sclk, if1.spi_sclk, if0.spi_sclk};
    assign obs_mosi = {if2.spi_mosi, if1.spi_mosi, if0.spi_mosi};
    assign obs_rdy  = {if2.tx_ready, if1.tx_ready, if0.tx_ready};
    assign obs_busy = {if2.busy,     if1.busy,     if0.busy};
    assign obs_rxv  = {if2.rx_valid, if1.rx_valid, if0.rx_valid};
    assign obs_rxd[0] = if0.rx_data;
    assign obs_rxd[1] = if1.rx_data;
    assign obs_rxd[2] = {8'h00, if2.rx_data};

    function automatic int cfg_n(input int d);    return (d == 2) ? 8 : 16; endfunction
    function automatic int cfg_d(input int d);    return (d == 2) ? 1 : 4;  endfunction
    function automatic int cfg_s(input int d);    return (d == 2) ? 1 : 2;  endfunction
    function automatic int cfg_g(input int d);    return 2;                 endfunction
    function automatic logic cfg_cpol(input int d);  return (d == 1);       endfunction
    function automatic logic cfg_cs_on(input int d); return (d == 2);       endfunction

    typedef struct {
        int          t_rx;
        logic [15:0] rx;
        int          n_rxv;
        int          cs_cnt;
        int          first_cs;
        int          n_edges;
        int          first_edge;
        logic        mosi_fe;
        int          t_ready;
        logic        busy1;
        logic [15:0] rx_hold;
        logic        sclk_pre;
        logic        sclk_post;
    } res_t;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input int d);
        int guard = 0;
        while (obs_rdy[d] !== 1'b1 && guard < 400) begin
            tick();
            guard++;
        end
        chk($sformatf("d%0d_ready_wait", d), {31'd0, obs_rdy[d]}, 32'd1);
    endtask

    // One transfer; cycle 0 is the cycle in which the command is accepted.
    task automatic xfer(input int d, input logic [15:0] w, output res_t r);
        logic prev;
        wait_ready(d);
        r = '{t_rx: -1, rx: '0, n_rxv: 0, cs_cnt: 0, first_cs: -1, n_edges: 0,
              first_edge: -1, mosi_fe: 1'b0, t_ready: -1, busy1: 1'b0,
              rx_hold: '0, sclk_pre: obs_sclk[d], sclk_post: 1'bx};
        tv[d] = 1'b1;
        td[d] = w;
        prev  = obs_sclk[d];
        tick();
        tv[d] = 1'b0;
        for (int t = 1; t <= 600; t++) begin
            if (obs_cs[d] == cfg_cs_on(d)) begin
                r.cs_cnt++;
                if (r.first_cs < 0) r.first_cs = t;
            end
            if (obs_sclk[d] != prev) begin
                r.n_edges++;
                if (r.first_edge < 0) begin
                    r.first_edge = t;
                    r.mosi_fe    = obs_mosi[d];
                end
            end
            prev = obs_sclk[d];
            if (obs_rxv[d]) begin
                r.n_rxv++;
                r.t_rx = t;
                r.rx   = obs_rxd[d];
            end
            if (t == 1) r.busy1 = obs_busy[d] && !obs_rdy[d];
            if (obs_rdy[d]) begin
                r.t_ready   = t;
                r.rx_hold   = obs_rxd[d];
                r.sclk_post = obs_sclk[d];
                break;
            end
            tick();
        end
    endtask

    task automatic check_xfer(input int d, input logic [15:0] w, input logic [15:0] exp_rx,
                              input res_t r);
        int n  = cfg_n(d);
        int t_rx_exp = 1 + cfg_s(d) + 2 * n * cfg_d(d);
        chk($sformatf("d%0d_rx_data", d),    {16'd0, r.rx},      {16'd0, exp_rx});
        chk($sformatf("d%0d_rx_cycle", d),   r.t_rx,             t_rx_exp);
        chk($sformatf("d%0d_rx_pulses", d),  r.n_rxv,            1);
        chk($sformatf("d%0d_cs_cycles", d),  r.cs_cnt,           t_rx_exp - 1);
        chk($sformatf("d%0d_cs_first", d),   r.first_cs,         1);
        chk($sformatf("d%0d_sclk_edges", d), r.n_edges,          2 * n);
        chk($sformatf("d%0d_edge0_cyc", d),  r.first_edge,       1 + cfg_s(d));
        chk($sformatf("d%0d_mosi_edge0", d), {31'd0, r.mosi_fe}, {31'd0, w[n-1]});
        chk($sformatf("d%0d_ready_cyc", d),  r.t_ready,          t_rx_exp + cfg_g(d));
        chk($sformatf("d%0d_busy_c1", d),    {31'd0, r.busy1},   32'd1);
        chk($sformatf("d%0d_rx_hold", d),    {16'd0, r.rx_hold}, {16'd0, exp_rx});
        chk($sformatf("d%0d_sclk_pre", d),   {31'd0, r.sclk_pre},  {31'd0, cfg_cpol(d)});
        chk($sformatf("d%0d_sclk_post", d),  {31'd0, r.sclk_post}, {31'd0, cfg_cpol(d)});
    endtask

    task automatic back_to_back();
        int t_rx [2];
        logic [15:0] v_rx [2];
        int n_rx = 0, gap = 0;
        bit gap_done = 0, acc;
        wait_ready(0);
        tv[0] = 1'b1;
        td[0] = 16'h0001;
        tick();
        td[0] = 16'h8000;
        for (int t = 1; t <= 400 && n_rx < 2; t++) begin
            if (obs_rxv[0]) begin
                t_rx[n_rx] = t;
                v_rx[n_rx] = obs_rxd[0];
                n_rx++;
            end
            if (n_rx >= 1 && !gap_done) begin
                if (obs_cs[0] != cfg_cs_on(0)) gap++;
                else gap_done = 1;
            end
            acc = obs_rdy[0] && tv[0];
            tick();
            if (acc) begin
                tv[0] = 1'b0;
                td[0] = 16'h7777;
            end
        end
        tv[0] = 1'b0;
        chk("b2b_pulses", n_rx, 2);
        if (n_rx == 2) begin
            chk("b2b_rx0", {16'd0, v_rx[0]}, 32'h0001);
            chk("b2b_rx1", {16'd0, v_rx[1]}, 32'h8000);
            chk("b2b_period", t_rx[1] - t_rx[0], 1 + 2 + 2 * 16 * 4 + 2);
            chk("b2b_cs_gap", gap, 2 + 1);
        end
    endtask

    task automatic reset_mid();
        res_t r;
        int n_rxv = 0;
        wait_ready(0);
        tv[0] = 1'b1;
        td[0] = 16'($urandom);
        tick();
        tv[0] = 1'b0;
        repeat (49) tick();
        rstn[0] = 1'b0;
        tick();
        chk("rst_mid_cs",    {31'd0, obs_cs[0]},   32'd1);
        chk("rst_mid_sclk",  {31'd0, obs_sclk[0]}, 32'd0);
        chk("rst_mid_ready", {31'd0, obs_rdy[0]},  32'd0);
        chk("rst_mid_busy",  {31'd0, obs_busy[0]}, 32'd0);
        chk("rst_mid_rxd",   {16'd0, obs_rxd[0]},  32'd0);
        n_rxv += int'(obs_rxv[0]);
        repeat (3) begin
            tick();
            n_rxv += int'(obs_rxv[0]);
        end
        rstn[0] = 1'b1;
        repeat (150) begin
            tick();
            n_rxv += int'(obs_rxv[0]);
        end
        chk("rst_mid_no_rxv", n_rxv, 0);
        xfer(0, 16'hFFFF, r);
        check_xfer(0, 16'hFFFF, 16'hFFFF, r);
    endtask

    initial begin
        res_t r;
        logic [15:0] w, sw;
        for (int d = 0; d < 3; d++) begin
            rstn[d] = 1'b0;
            tv[d]   = 1'b0;
            td[d]   = '0;
        end
        s_word = 16'hCAFE;

        repeat (5) tick();
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("d%0d_rst_ready", d), {31'd0, obs_rdy[d]},  32'd0);
            chk($sformatf("d%0d_rst_busy", d),  {31'd0, obs_busy[d]}, 32'd0);
            chk($sformatf("d%0d_rst_rxv", d),   {31'd0, obs_rxv[d]},  32'd0);
            chk($sformatf("d%0d_rst_rxd", d),   {16'd0, obs_rxd[d]},  32'd0);
            chk($sformatf("d%0d_rst_sclk", d),  {31'd0, obs_sclk[d]}, {31'd0, cfg_cpol(d)});
            chk($sformatf("d%0d_rst_mosi", d),  {31'd0, obs_mosi[d]}, 32'd0);
            chk($sformatf("d%0d_rst_cs", d),    {31'd0, obs_cs[d]},   {31'd0, ~cfg_cs_on(d)});
        end
        for (int d = 0; d < 3; d++) rstn[d] = 1'b1;

        xfer(0, 16'hA5C3, r);
        check_xfer(0, 16'hA5C3, 16'hA5C3, r);

        xfer(1, 16'h1234, r);
        check_xfer(1, 16'h1234, 16'hCAFE, r);
        chk("d1_slave_rx", {16'd0, s_rx}, 32'h1234);

        xfer(2, 16'h005A, r);
        check_xfer(2, 16'h005A, 16'h005A, r);

        for (int i = 0; i < 3; i++) begin
            w = 16'($urandom);
            xfer(0, w, r);
            check_xfer(0, w, w, r);

            w  = 16'($urandom);
            sw = 16'($urandom);
            s_word = sw;
            xfer(1, w, r);
            check_xfer(1, w, sw, r);
            chk("d1_slave_rx_rand", {16'd0, s_rx}, {16'd0, w});

            w = 16'($urandom) & 16'h00FF;
            xfer(2, w, r);
            check_xfer(2, w, w, r);
        end

        back_to_back();
        reset_mid();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
